// File: rtl/climate_sort_sequencer.sv
// Climate sort sequencer: loads six thresholds from the trained-set memory, then per sample tick
// classifies Temp/Desired_Temp/time-at-setpoint and fetches the valve pattern. Option: SORT_SEQ_OVERRUN_EN.
module climate_sort_sequencer #(
    parameter int unsigned SAMPLE_PERIOD = 100,
    parameter int unsigned TIME_MAX      = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       cfg_reload,
    input  logic [6:0] Temp,
    input  logic [6:0] Desired_Temp,
    output logic       mem_req,
    output logic [9:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [8:0] addr_out,
    output logic [5:0] valve_out,
    output logic       valve_valid,
    output logic       busy,
    output logic       cfg_ok
`ifdef SORT_SEQ_OVERRUN_EN
    ,
    output logic [7:0] overrun_cnt
`endif
);

    typedef enum logic [2:0] {
        CFG      = 3'd0,
        IDLE     = 3'd1,
        CLASSIFY = 3'd2,
        LOOKUP   = 3'd3,
        APPLY    = 3'd4
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(SAMPLE_PERIOD - 1);
    localparam logic [5:0]  TIME_SAT  = 6'(TIME_MAX);

    state_t      state_q;
    logic [15:0] tick_cnt_q;
    logic        pending_q, reload_q, seen_q;
    logic [2:0]  cfg_idx_q;
    logic [6:0]  lb_temp_q, ub_temp_q, desired_prev_q;
    logic [5:0]  lb_time_q, ub_time_q, time_q, rdata_q;
    logic [7:0]  ub_change_q, lb_change_q;
    logic        mem_req_q, valve_valid_q, busy_q, cfg_ok_q;
    logic [9:0]  mem_addr_q;
    logic [8:0]  addr_out_q;
    logic [5:0]  valve_out_q;

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign addr_out    = addr_out_q;
    assign valve_out   = valve_out_q;
    assign valve_valid = valve_valid_q;
    assign busy        = busy_q;
    assign cfg_ok      = cfg_ok_q;

    // Band rule shared by Temp and time: the lower test wins when thresholds overlap.
    function automatic logic [2:0] band(input logic [6:0] value, input logic [6:0] lb,
                                        input logic [6:0] ub);
        if (value <= lb)      return 3'd1;
        else if (value >= ub) return 3'd3;
        return 3'd2;
    endfunction

    logic tick, in_idle, take_reload, take_sample, tick_to_pending;
    assign tick            = enable && (tick_cnt_q == TICK_LAST);
    assign in_idle         = (state_q == IDLE);
    assign take_reload     = in_idle && (cfg_reload || reload_q);
    assign take_sample     = in_idle && !take_reload && (tick || pending_q);
    assign tick_to_pending = tick && (!in_idle || take_reload);

    // Change limits are 9-bit so Desired_Temp+ub_change cannot wrap.
    logic [8:0] temp_ext, desired_ext, upper_lim, lower_lim;
    assign temp_ext    = {2'b00, Temp};
    assign desired_ext = {2'b00, Desired_Temp};
    assign upper_lim   = desired_ext + {1'b0, ub_change_q};
    assign lower_lim   = desired_ext - {1'b0, lb_change_q};

    logic [5:0] time_d;
    logic [2:0] temp_state, change_state, time_state;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        time_d       = 6'd0;
        change_state = 3'd2;
        if (seen_q && (Desired_Temp == desired_prev_q))
            time_d = (time_q >= TIME_SAT) ? TIME_SAT : time_q + 6'd1;
        if (temp_ext > upper_lim)
            change_state = 3'd1;
        else if (({1'b0, lb_change_q} <= desired_ext) && (temp_ext < lower_lim))
            change_state = 3'd3;
        temp_state = band(Temp, lb_temp_q, ub_temp_q);
        time_state = band({1'b0, time_d}, {1'b0, lb_time_q}, {1'b0, ub_time_q});
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt_q <= '0;
        else if (!enable || (tick_cnt_q == TICK_LAST))
            tick_cnt_q <= '0;
        else
            tick_cnt_q <= tick_cnt_q + 16'd1;
    end

    // NOTE: threshold registers are reset too; the design relies on cfg_ok, not on
    // their contents, but a known value keeps simulation and silicon in step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= CFG;
            pending_q      <= 1'b0;
            reload_q       <= 1'b0;
            seen_q         <= 1'b0;
            cfg_idx_q      <= '0;
            lb_temp_q      <= '0;
            ub_temp_q      <= '0;
            lb_time_q      <= '0;
            ub_time_q      <= '0;
            ub_change_q    <= '0;
            lb_change_q    <= '0;
            desired_prev_q <= '0;
            time_q         <= '0;
            rdata_q        <= '0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            addr_out_q     <= '0;
            valve_out_q    <= '0;
            valve_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
            cfg_ok_q       <= 1'b0;
        end else begin
            valve_valid_q <= 1'b0;
            busy_q        <= 1'b1;

            if (!enable)
                pending_q <= 1'b0;
            else if (tick_to_pending)
                pending_q <= 1'b1;
            else if (take_sample)
                pending_q <= tick && pending_q;

            if (take_reload)
                reload_q <= 1'b0;
            else if (cfg_reload)
                reload_q <= 1'b1;

            case (state_q)
                CFG: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {1'b1, 6'd0, cfg_idx_q};
                    end else if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        case (cfg_idx_q)
                            3'd0:    lb_temp_q   <= mem_rdata[6:0];
                            3'd1:    ub_temp_q   <= mem_rdata[6:0];
                            3'd2:    lb_time_q   <= mem_rdata[5:0];
                            3'd3:    ub_time_q   <= mem_rdata[5:0];
                            3'd4:    ub_change_q <= mem_rdata;
                            default: lb_change_q <= mem_rdata;
                        endcase
                        if (cfg_idx_q == 3'd5) begin
                            cfg_idx_q <= '0;
                            cfg_ok_q  <= 1'b1;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                        end else begin
                            cfg_idx_q <= cfg_idx_q + 3'd1;
                        end
                    end
                end
                IDLE: begin
                    busy_q <= take_reload || take_sample;
                    if (take_reload)
                        state_q <= CFG;
                    else if (take_sample)
                        state_q <= CLASSIFY;
                end
                CLASSIFY: begin
                    addr_out_q     <= {temp_state, change_state, time_state};
                    time_q         <= time_d;
                    desired_prev_q <= Desired_Temp;
                    seen_q         <= 1'b1;
                    state_q        <= LOOKUP;
                end
                LOOKUP: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {1'b0, addr_out_q};
                    end else if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        rdata_q   <= mem_rdata[5:0];
                        state_q   <= APPLY;
                    end
                end
                APPLY: begin
                    valve_out_q   <= rdata_q;
                    valve_valid_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: state_q <= CFG;
            endcase
        end
    end

`ifdef SORT_SEQ_OVERRUN_EN
    logic [7:0] overrun_q;
    logic       tick_dropped;
    assign tick_dropped = tick_to_pending && pending_q;
    assign overrun_cnt  = overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun_q <= '0;
        else if (cfg_reload)
            overrun_q <= '0;
        else if (tick_dropped && (overrun_q != 8'hFF))
            overrun_q <= overrun_q + 8'd1;
    end
`endif

endmodule

// File: tb/tb_climate_sort_sequencer.sv
// Directed bench for climate_sort_sequencer with a behavioural trained-set memory
// (2-cycle ack delay, optional ack withholding) and a table of classification vectors.
module tb_climate_sort_sequencer;

    localparam int P = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       cfg_reload = 1'b0;
    logic [6:0] Temp = '0;
    logic [6:0] Desired_Temp = '0;
    logic       mem_req;
    logic [9:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = '0;
    logic [8:0] addr_out;
    logic [5:0] valve_out;
    logic       valve_valid, busy, cfg_ok;
`ifdef SORT_SEQ_OVERRUN_EN
    logic [7:0] overrun_cnt;
`endif

    climate_sort_sequencer #(.SAMPLE_PERIOD(P), .TIME_MAX(63)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_reload(cfg_reload),
        .Temp(Temp), .Desired_Temp(Desired_Temp),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .addr_out(addr_out), .valve_out(valve_out), .valve_valid(valve_valid),
        .busy(busy), .cfg_ok(cfg_ok)
`ifdef SORT_SEQ_OVERRUN_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         proto_err = 0;
    bit         mem_hold = 1'b0;
    int         ack_delay = 2;
    logic [7:0] cfg_mem [6];
    logic [9:0] addr_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int cycles);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out after %0d cycles", name, cycles);
    endtask

    function automatic logic [7:0] mem_data(input logic [9:0] a);
        if (a[9])
            return (a[2:0] < 3'd6) ? cfg_mem[a[2:0]] : 8'h00;
        return {2'b11, a[5:0] ^ 6'h3B};
    endfunction

    // Memory model: logs each request, checks address stability and the low gap, acks after ack_delay.
    initial begin : mem_model
        int         wait_cnt;
        bit         req_seen;
        logic [9:0] req_addr;
        wait_cnt = 0;
        req_seen = 1'b0;
        req_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack  = 1'b0;
                req_seen = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                if (mem_req) proto_err++;
            end else if (mem_req) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    wait_cnt = 0;
                    req_addr = mem_addr;
                    addr_log.push_back(mem_addr);
                end else if (mem_addr != req_addr) begin
                    proto_err++;
                end
                if (!mem_hold) begin
                    if (wait_cnt >= ack_delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_data(req_addr);
                        req_seen  = 1'b0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // Waits for the next valve update and checks address, pattern and one-cycle pulse width.
    task automatic wait_valid(input string name, input logic [8:0] exp_addr);
        int         cyc;
        logic [5:0] exp_valve;
        cyc = 0;
        while (!valve_valid && cyc < 4 * P) begin
            @(negedge clk);
            cyc++;
        end
        if (!valve_valid) begin
            timeout_fail(name, cyc);
            return;
        end
        exp_valve = exp_addr[5:0] ^ 6'h3B;
        check({name, "_addr"}, 32'(addr_out), 32'(exp_addr));
        check({name, "_valve"}, 32'(valve_out), 32'(exp_valve));
        @(negedge clk);
        check({name, "_pulse"}, 32'(valve_valid), 32'd0);
    endtask

    // Waits for a complete six-read config load and checks its addresses.
    task automatic wait_cfg(input string name);
        int cyc;
        cyc = 0;
        while (!(addr_log.size() >= 6 && !busy) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (addr_log.size() < 6 || busy) begin
            timeout_fail(name, cyc);
            return;
        end
        check({name, "_reads"}, 32'(addr_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_addr%0d", name, i), 32'(addr_log[i]), 32'(10'h200 + 10'(i)));
        check({name, "_cfg_ok"}, 32'(cfg_ok), 32'd1);
    endtask

    typedef struct {
        logic [6:0] t;
        logic [6:0] d;
        logic [8:0] exp_addr;
    } vec_t;

    vec_t vecs [12];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int         cyc;
        int         pulses;
        int         tf;
        logic [2:0] ts;

        cfg_mem[0] = 8'd20; cfg_mem[1] = 8'd30; cfg_mem[2] = 8'd5;
        cfg_mem[3] = 8'd40; cfg_mem[4] = 8'd3;  cfg_mem[5] = 8'd2;

        // thresholds 20,30,5,40,3,2: {Temp_state, change_state, time_state}
        vecs[0]  = '{7'd25,  7'd25,  9'h091};
        vecs[1]  = '{7'd25,  7'd25,  9'h091};
        vecs[2]  = '{7'd35,  7'd20,  9'h0C9};
        vecs[3]  = '{7'd15,  7'd20,  9'h059};
        vecs[4]  = '{7'd20,  7'd20,  9'h051};
        vecs[5]  = '{7'd30,  7'd20,  9'h0C9};
        vecs[6]  = '{7'd23,  7'd20,  9'h091};
        vecs[7]  = '{7'd24,  7'd20,  9'h089};
        vecs[8]  = '{7'd18,  7'd20,  9'h052};
        vecs[9]  = '{7'd17,  7'd20,  9'h05A};
        vecs[10] = '{7'd0,   7'd1,   9'h051};
        vecs[11] = '{7'd127, 7'd127, 9'h0D1};

        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_ok", 32'(cfg_ok), 32'd0);
        check("rst_valve_out", 32'(valve_out), 32'd0);
        check("rst_valve_valid", 32'(valve_valid), 32'd0);
        check("rst_addr_out", 32'(addr_out), 32'd0);

        rst_n = 1'b1;
        wait_cfg("cfg_load");

        pulses = 0;
        repeat (3 * P) begin
            @(negedge clk);
            if (valve_valid) pulses++;
        end
        check("disabled_no_samples", 32'(pulses), 32'd0);
        check("disabled_no_reads", 32'(addr_log.size()), 32'd6);

        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            Temp         = vecs[i].t;
            Desired_Temp = vecs[i].d;
            wait_valid($sformatf("vec%0d", i), vecs[i].exp_addr);
        end

        Temp         = 7'd25;
        Desired_Temp = 7'd25;
        for (int k = 0; k < 70; k++) begin
            tf = (k > 63) ? 63 : k;
            ts = (tf <= 5) ? 3'd1 : ((tf >= 40) ? 3'd3 : 3'd2);
            wait_valid($sformatf("sat%0d", k), {3'd2, 3'd2, ts});
        end
        Desired_Temp = 7'd26;
        wait_valid("setpoint_step", 9'h091);

        cfg_mem[0] = 8'd26;
        addr_log.delete();
        cfg_reload = 1'b1;
        @(negedge clk);
        cfg_reload = 1'b0;
        wait_cfg("reload");
        wait_valid("reload_apply", 9'h051);

        mem_hold = 1'b1;
        cyc = 0;
        while (!mem_req && cyc < 4 * P) begin
            @(negedge clk);
            cyc++;
        end
        if (!mem_req) timeout_fail("overrun_req", cyc);
        repeat (3 * P) @(negedge clk);
        mem_hold = 1'b0;
        pulses = 0;
        repeat (16) begin
            @(negedge clk);
            if (valve_valid) begin
                pulses++;
                check($sformatf("overrun_addr%0d", pulses), 32'(addr_out), 32'h051);
            end
        end
        check("overrun_samples", 32'(pulses), 32'd2);
`ifdef SORT_SEQ_OVERRUN_EN
        check("overrun_cnt", 32'(overrun_cnt), 32'd2);
`endif

        mem_hold = 1'b1;
        cyc = 0;
        while (!mem_req && cyc < 4 * P) begin
            @(negedge clk);
            cyc++;
        end
        if (!mem_req) timeout_fail("abort_req", cyc);
        check("abort_in_lookup", 32'(mem_addr[9]), 32'd0);
        check("abort_busy_before", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_valve_out", 32'(valve_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cfg_ok", 32'(cfg_ok), 32'd0);
        check("abort_addr_out", 32'(addr_out), 32'd0);
        addr_log.delete();
        mem_hold = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cfg("restart");

        check("mem_protocol", 32'(proto_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
